// File: rtl/aes_enc_ctrl_if.sv
// aes_enc_ctrl_if
//  Bundles the register-block side (request in, result/status out) and the
//  AES core side (load/data out, done/data in) of the encryption sequencer.
//  Signal names are written from the sequencer's point of view.
//  Modports:
//   slave  - the sequencer (aes_enc_ctrl)
//   master - the environment: register block plus AES core
//  Signals:
//   start_i      request strobe, one cycle
//   plaintext_i  plaintext, sampled with start_i
//   clr_i        clears done_o / timeout_o / overrun_o
//   core_ld_o    one-cycle load pulse to the core
//   core_data_o  block presented to the core
//   core_done_i  core result valid, one cycle
//   core_data_i  core ciphertext
//   ciphertext_o last captured ciphertext
//   done_o       sticky fresh-result flag
//   busy_o       sequencer busy or pending buffer full
//   timeout_o    sticky watchdog flag
//   overrun_o    sticky dropped-request flag
interface aes_enc_ctrl_if #(
  parameter int DATA_W = 128
);
  logic              start_i;
  logic [DATA_W-1:0] plaintext_i;
  logic              clr_i;
  logic              core_ld_o;
  logic [DATA_W-1:0] core_data_o;
  logic              core_done_i;
  logic [DATA_W-1:0] core_data_i;
  logic [DATA_W-1:0] ciphertext_o;
  logic              done_o;
  logic              busy_o;
  logic              timeout_o;
  logic              overrun_o;

  modport slave (
    input  start_i, plaintext_i, clr_i, core_done_i, core_data_i,
    output core_ld_o, core_data_o, ciphertext_o, done_o, busy_o,
           timeout_o, overrun_o
  );

  modport master (
    output start_i, plaintext_i, clr_i, core_done_i, core_data_i,
    input  core_ld_o, core_data_o, ciphertext_o, done_o, busy_o,
           timeout_o, overrun_o
  );
endinterface

// File: rtl/aes_enc_ctrl.sv
// aes_enc_ctrl
//  Sequencer between the AES register block and the AES encryption core.
//  A start request latches the plaintext, pulses the core load for one
//  cycle, then waits for the core's done under a watchdog. The result is
//  captured into ciphertext_o with a sticky done flag. One extra request
//  arriving while busy is held in a 1-deep pending buffer; a further one
//  is dropped and flagged as overrun.
//  Ports:
//   wb_clk_i    clock
//   wb_rst_n_i  asynchronous active-low reset
//   ctrl_if     request/result/status and core handshake (slave modport)
//  All outputs are registered.
module aes_enc_ctrl #(
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 6
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  aes_enc_ctrl_if.slave ctrl_if
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_vld_q, pend_vld_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [DATA_W-1:0] core_data_q, core_data_d;
  logic [DATA_W-1:0] ct_q, ct_d;
  logic              ld_q, ld_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              to_q, to_d;
  logic              ovr_q, ovr_d;
  logic              start_taken;
  logic              wait_exit;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      core_data_q <= '0;
      ct_q        <= '0;
      ld_q        <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      to_q        <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      core_data_q <= core_data_d;
      ct_q        <= ct_d;
      ld_q        <= ld_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      to_q        <= to_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    core_data_d = core_data_q;
    ct_d        = ct_q;
    done_d      = done_q;
    to_d        = to_q;
    ovr_d       = ovr_q;
    start_taken = 1'b0;
    wait_exit   = 1'b0;

    // Clear first so that a same-cycle capture or error event overrides it.
    if (ctrl_if.clr_i) begin
      done_d = 1'b0;
      to_d   = 1'b0;
      ovr_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ctrl_if.start_i) begin
          core_data_d = ctrl_if.plaintext_i;
          done_d      = 1'b0;
          start_taken = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        // A dispatched pending request retires the previous result here.
        cnt_d   = '0;
        done_d  = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (ctrl_if.core_done_i) begin
          ct_d      = ctrl_if.core_data_i;
          done_d    = 1'b1;
          wait_exit = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          to_d      = 1'b1;
          wait_exit = 1'b1;
        end
        if (wait_exit) begin
          if (pend_vld_q) begin
            core_data_d = pend_data_q;
            pend_vld_d  = 1'b0;
            state_d     = LOAD;
          end else if (ctrl_if.start_i) begin
            // Request arriving as the sequencer frees up launches directly.
            core_data_d = ctrl_if.plaintext_i;
            start_taken = 1'b1;
            state_d     = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A request not launched directly goes to the pending slot; if the slot
    // is still occupied after this cycle's dispatch, the request is dropped.
    if (ctrl_if.start_i && !start_taken) begin
      if (!pend_vld_d) begin
        pend_vld_d  = 1'b1;
        pend_data_d = ctrl_if.plaintext_i;
      end else begin
        ovr_d = 1'b1;
      end
    end

    ld_d   = (state_d == LOAD);
    busy_d = (state_d != IDLE) || pend_vld_d;
  end

  assign ctrl_if.core_ld_o    = ld_q;
  assign ctrl_if.core_data_o  = core_data_q;
  assign ctrl_if.ciphertext_o = ct_q;
  assign ctrl_if.done_o       = done_q;
  assign ctrl_if.busy_o       = busy_q;
  assign ctrl_if.timeout_o    = to_q;
  assign ctrl_if.overrun_o    = ovr_q;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// tb_aes_enc_ctrl
//  Directed bench for aes_enc_ctrl. The AES core is played by the stimulus
//  sequence itself, which raises core_done_i at fixed cycle offsets.
//  Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_aes_enc_ctrl;
  localparam int DATA_W = 128;

  localparam logic [DATA_W-1:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DATA_W-1:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [DATA_W-1:0] PA5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] P2  = 128'h0202_0202_0202_0202_0202_0202_0202_0202;
  localparam logic [DATA_W-1:0] C2  = 128'hc2c2_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [DATA_W-1:0] C3  = 128'hc3c3_7777_8888_9999_aaaa_bbbb_cccc_dddd;
  localparam logic [DATA_W-1:0] P4  = 128'h0404_0404_0404_0404_0404_0404_0404_0404;
  localparam logic [DATA_W-1:0] P5  = 128'h0505_0505_0505_0505_0505_0505_0505_0505;
  localparam logic [DATA_W-1:0] P6  = 128'h0606_0606_0606_0606_0606_0606_0606_0606;
  localparam logic [DATA_W-1:0] C4  = 128'hc4c4_c4c4_c4c4_c4c4_c4c4_c4c4_c4c4_c4c4;
  localparam logic [DATA_W-1:0] C5  = 128'hc5c5_1234_5678_9abc_def0_0fed_cba9_8765;
  localparam logic [DATA_W-1:0] P7  = 128'h0707_0707_0707_0707_0707_0707_0707_0707;
  localparam logic [DATA_W-1:0] P8  = 128'h0808_0808_0808_0808_0808_0808_0808_0808;
  localparam logic [DATA_W-1:0] C6  = 128'hc6c6_c6c6_c6c6_c6c6_c6c6_c6c6_c6c6_c6c6;
  localparam logic [DATA_W-1:0] P9  = 128'h0909_0909_0909_0909_0909_0909_0909_0909;
  localparam logic [DATA_W-1:0] C7  = 128'hc7c7_c7c7_c7c7_c7c7_c7c7_c7c7_c7c7_c7c7;
  localparam logic [DATA_W-1:0] C8  = 128'hc8c8_0101_0202_0303_0404_0505_0606_0707;
  localparam logic [DATA_W-1:0] P10 = 128'h1010_1010_1010_1010_1010_1010_1010_1010;
  localparam logic [DATA_W-1:0] C9  = 128'hc9c9_fefe_dcdc_baba_9898_7676_5454_3232;
  localparam logic [DATA_W-1:0] P11 = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
  localparam logic [DATA_W-1:0] P12 = 128'h1212_1212_1212_1212_1212_1212_1212_1212;
  localparam logic [DATA_W-1:0] P13 = 128'h1313_1313_1313_1313_1313_1313_1313_1313;
  localparam logic [DATA_W-1:0] ZERO = '0;
  localparam logic [DATA_W-1:0] ONE  = 128'd1;

  logic clk;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  aes_enc_ctrl_if #(.DATA_W(DATA_W)) bus ();

  aes_enc_ctrl #(
    .DATA_W (DATA_W),
    .TIMEOUT(32),
    .CNT_W  (6)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .ctrl_if   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [DATA_W-1:0] pt);
    bus.start_i     = 1'b1;
    bus.plaintext_i = pt;
    tick();
    bus.start_i     = 1'b0;
    bus.plaintext_i = '0;
  endtask

  task automatic core_done(input logic [DATA_W-1:0] ct);
    bus.core_done_i = 1'b1;
    bus.core_data_i = ct;
    tick();
    bus.core_done_i = 1'b0;
    bus.core_data_i = '0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.start_i     = 1'b0;
    bus.plaintext_i = '0;
    bus.clr_i       = 1'b0;
    bus.core_done_i = 1'b0;
    bus.core_data_i = '0;
    tick(2);

    // Reset state
    chk("rst_ld",   ZERO | bus.core_ld_o,  ZERO);
    chk("rst_cd",   bus.core_data_o,       ZERO);
    chk("rst_ct",   bus.ciphertext_o,      ZERO);
    chk("rst_done", ZERO | bus.done_o,     ZERO);
    chk("rst_busy", ZERO | bus.busy_o,     ZERO);
    chk("rst_to",   ZERO | bus.timeout_o,  ZERO);
    chk("rst_ovr",  ZERO | bus.overrun_o,  ZERO);
    rst_n = 1'b1;
    tick();

    // T1 basic: load one cycle after start, done 21 cycles after load
    start(P1);
    chk("t1_ld",     ZERO | bus.core_ld_o, ONE);
    chk("t1_cd",     bus.core_data_o,      P1);
    chk("t1_busy",   ZERO | bus.busy_o,    ONE);
    tick();
    chk("t1_ld_off", ZERO | bus.core_ld_o, ZERO);
    tick(20);
    chk("t1_done_pre", ZERO | bus.done_o,  ZERO);
    core_done(C1);
    chk("t1_done",   ZERO | bus.done_o,    ONE);
    chk("t1_ct",     bus.ciphertext_o,     C1);
    chk("t1_busy0",  ZERO | bus.busy_o,    ZERO);

    // T2 queue: second request during WAIT dispatched right after done
    start(P2);
    chk("t2_done_clr", ZERO | bus.done_o,  ZERO);
    tick();
    start(PA5);
    chk("t2_cd_hold", bus.core_data_o,     P2);
    chk("t2_busy",    ZERO | bus.busy_o,   ONE);
    tick(3);
    core_done(C2);
    chk("t2_ld",     ZERO | bus.core_ld_o, ONE);
    chk("t2_cd",     bus.core_data_o,      PA5);
    chk("t2_done",   ZERO | bus.done_o,    ONE);
    chk("t2_ct",     bus.ciphertext_o,     C2);
    chk("t2_ovr",    ZERO | bus.overrun_o, ZERO);
    tick();
    chk("t2_done_ld", ZERO | bus.done_o,   ZERO);
    chk("t2_ld_off", ZERO | bus.core_ld_o, ZERO);
    tick(2);
    core_done(C3);
    chk("t2_done2",  ZERO | bus.done_o,    ONE);
    chk("t2_ct2",    bus.ciphertext_o,     C3);
    chk("t2_busy0",  ZERO | bus.busy_o,    ZERO);

    // T3 overrun: third request dropped, pending keeps the second
    start(P4);
    tick();
    start(P5);
    start(P6);
    chk("t3_ovr",    ZERO | bus.overrun_o, ONE);
    core_done(C4);
    chk("t3_ld",     ZERO | bus.core_ld_o, ONE);
    chk("t3_cd",     bus.core_data_o,      P5);
    tick();
    core_done(C5);
    chk("t3_busy0",  ZERO | bus.busy_o,    ZERO);
    chk("t3_ct",     bus.ciphertext_o,     C5);
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    chk("t3_ovr_clr",  ZERO | bus.overrun_o, ZERO);
    chk("t3_done_clr", ZERO | bus.done_o,    ZERO);

    // T4 timeout: no done for 32 WAIT cycles
    start(P7);
    tick();
    tick(31);
    chk("t4_to_pre", ZERO | bus.timeout_o, ZERO);
    chk("t4_busy_pre", ZERO | bus.busy_o,  ONE);
    tick();
    chk("t4_to",     ZERO | bus.timeout_o, ONE);
    chk("t4_busy0",  ZERO | bus.busy_o,    ZERO);
    chk("t4_ct",     bus.ciphertext_o,     C5);
    chk("t4_done",   ZERO | bus.done_o,    ZERO);
    chk("t4_ld",     ZERO | bus.core_ld_o, ZERO);
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    chk("t4_to_clr", ZERO | bus.timeout_o, ZERO);

    // T5 reset at WAIT cycle 10
    start(P8);
    tick();
    tick(9);
    chk("t5_busy_pre", ZERO | bus.busy_o,  ONE);
    rst_n = 1'b0;
    #1;
    chk("t5_ld",     ZERO | bus.core_ld_o, ZERO);
    chk("t5_cd",     bus.core_data_o,      ZERO);
    chk("t5_ct",     bus.ciphertext_o,     ZERO);
    chk("t5_done",   ZERO | bus.done_o,    ZERO);
    chk("t5_busy",   ZERO | bus.busy_o,    ZERO);
    chk("t5_to",     ZERO | bus.timeout_o, ZERO);
    chk("t5_ovr",    ZERO | bus.overrun_o, ZERO);
    tick();
    rst_n = 1'b1;
    tick();
    core_done(C6);
    chk("t5_late_done", ZERO | bus.done_o, ZERO);
    chk("t5_late_ct",   bus.ciphertext_o,  ZERO);
    chk("t5_late_busy", ZERO | bus.busy_o, ZERO);

    // T6 corners: done on the timeout cycle wins
    start(P9);
    tick();
    tick(31);
    core_done(C8);
    chk("t6_tc_done", ZERO | bus.done_o,    ONE);
    chk("t6_tc_to",   ZERO | bus.timeout_o, ZERO);
    chk("t6_tc_ct",   bus.ciphertext_o,     C8);
    chk("t6_tc_busy", ZERO | bus.busy_o,    ZERO);

    // core_done_i while IDLE is ignored
    core_done(C7);
    chk("t6_idle_ct", bus.ciphertext_o,     C8);

    // clr_i together with a capture: capture wins
    start(P10);
    chk("t6_start_done", ZERO | bus.done_o, ZERO);
    tick(4);
    bus.clr_i = 1'b1;
    core_done(C9);
    bus.clr_i = 1'b0;
    chk("t6_clr_done", ZERO | bus.done_o,   ONE);
    chk("t6_clr_ct",   bus.ciphertext_o,    C9);
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    chk("t6_clr_only", ZERO | bus.done_o,   ZERO);

    // clr_i together with an overrun: the flag is set
    start(P11);
    tick();
    start(P12);
    bus.clr_i = 1'b1;
    start(P13);
    bus.clr_i = 1'b0;
    chk("t6_clr_ovr",  ZERO | bus.overrun_o, ONE);
    core_done(C4);
    chk("t6_pend_cd",  bus.core_data_o,      P12);
    tick();
    core_done(C5);
    chk("t6_end_busy", ZERO | bus.busy_o,    ZERO);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
